// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and arithmetic helpers for the systolic array
package systolic_pkg;

  localparam logic MODE_OS = 1'b0;
  localparam logic MODE_WS = 1'b1;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 32;

  // Signed add of two values already sign-extended to 64 bits, judged against a
  // width-bit signed range (width must stay below 63). With saturate the result
  // clamps to the range limits; without it the caller truncates to width bits,
  // which yields the two's-complement wrap.
  function automatic longint sat_add(input longint a, input longint b, input int width,
                                     input logic saturate, output logic ovf);
    longint sum;
    longint max_v;
    longint min_v;
    sum   = a + b;
    max_v = (longint'(1) <<< (width - 1)) - longint'(1);
    min_v = -max_v - longint'(1);
    ovf   = (sum > max_v) || (sum < min_v);
    if (ovf && saturate) begin
      sum = (sum > max_v) ? max_v : min_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/pe_mult_stage.sv
// rtl/pe_mult_stage.sv - registered signed multiplier with valid/clear sideband
module pe_mult_stage
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [DATA_WIDTH-1:0]          a_i,
  input  logic [DATA_WIDTH-1:0]          b_i,
  input  logic                           vld_i,
  input  logic                           clr_i,
  input  logic                           flush_i,
  output logic signed [2*DATA_WIDTH-1:0] p_o,
  output logic                           vld_o,
  output logic                           clr_o
);

  logic signed [2*DATA_WIDTH-1:0] a_ext;
  logic signed [2*DATA_WIDTH-1:0] b_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [2*DATA_WIDTH-1:0] p_q;
  logic                           vld_q;
  logic                           clr_q;

  // Both operands widened first so the low 2*DATA_WIDTH product bits are the exact signed product.
  always_comb begin
    a_ext = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
    b_ext = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
    prod  = a_ext * b_ext;
  end

  // Product register; a flush drops the beat in flight together with its clear flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q   <= '0;
      vld_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      p_q   <= prod;
      vld_q <= vld_i & ~flush_i;
      clr_q <= clr_i & ~flush_i;
    end
  end

  assign p_o   = p_q;
  assign vld_o = vld_q;
  assign clr_o = clr_q;

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - systolic processing element with OS/WS dataflow and saturation
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int   DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int   ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter logic SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_vld_in,
  input  logic                  clr_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_vld_in,
  input  logic                  w_load,
  input  logic                  acc_load,
  input  logic                  acc_shift,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  psum_vld_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  a_vld_out,
  output logic                  b_vld_out,
  output logic                  clr_out,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  psum_vld_out,
  output logic                  sat_flag
);

  logic [DATA_WIDTH-1:0]          a_q;
  logic [DATA_WIDTH-1:0]          b_q;
  logic                           a_vld_q;
  logic                           b_vld_q;
  logic                           clr_q;
  logic                           mode_q;
  logic [DATA_WIDTH-1:0]          w_q;
  logic signed [ACC_WIDTH-1:0]    psum_in_q;
  logic                           psum_vld_in_q;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    acc_d;
  logic signed [ACC_WIDTH-1:0]    psum_q;
  logic signed [ACC_WIDTH-1:0]    psum_d;
  logic                           psum_vld_q;
  logic                           psum_vld_d;
  logic                           sat_q;
  logic                           sat_d;

  logic                           mode_chg;
  logic [DATA_WIDTH-1:0]          mult_b;
  logic                           mult_vld;
  logic signed [2*DATA_WIDTH-1:0] p;
  logic                           p_vld;
  logic                           p_clr;

  logic signed [63:0]             p_ext;
  logic signed [63:0]             os_base;
  logic signed [63:0]             os_sum_l;
  logic signed [63:0]             ws_addend;
  logic signed [63:0]             ws_sum_l;
  logic                           os_ovf;
  logic                           ws_ovf;
  logic signed [ACC_WIDTH-1:0]    os_sum;
  logic signed [ACC_WIDTH-1:0]    ws_sum;
  logic signed [ACC_WIDTH-1:0]    os_next;
  logic                           ws_vld;
  logic                           unused_hi;

  // Any edge of mode is seen for exactly one cycle, until mode_q catches up.
  assign mode_chg = mode ^ mode_q;
  assign mult_b   = (mode == MODE_WS) ? w_q : b_in;
  assign mult_vld = a_vld_in & ((mode == MODE_WS) | b_vld_in);

  pe_mult_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mult (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .a_i     (a_in),
    .b_i     (mult_b),
    .vld_i   (mult_vld),
    .clr_i   (clr_in),
    .flush_i (mode_chg),
    .p_o     (p),
    .vld_o   (p_vld),
    .clr_o   (p_clr)
  );

  // Operand forwarding, mode history, stationary weight and the WS psum stage aligned with the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      a_vld_q       <= 1'b0;
      b_vld_q       <= 1'b0;
      clr_q         <= 1'b0;
      mode_q        <= 1'b0;
      w_q           <= '0;
      psum_in_q     <= '0;
      psum_vld_in_q <= 1'b0;
    end else begin
      a_q           <= a_in;
      b_q           <= b_in;
      a_vld_q       <= a_vld_in;
      b_vld_q       <= b_vld_in;
      clr_q         <= clr_in;
      mode_q        <= mode;
      psum_in_q     <= psum_in;
      psum_vld_in_q <= psum_vld_in;
      if (w_load && b_vld_in) begin
        w_q <= b_in;
      end
    end
  end

  // Both datapath sums are formed every cycle; the stage-2 select below decides which one lands.
  always_comb begin
    p_ext     = longint'(p);
    os_base   = p_clr ? 64'sd0 : longint'(acc_q);
    os_ovf    = 1'b0;
    ws_ovf    = 1'b0;
    os_sum_l  = sat_add(os_base, p_ext, ACC_WIDTH, SATURATE, os_ovf);
    ws_addend = p_vld ? p_ext : 64'sd0;
    ws_sum_l  = sat_add(longint'(psum_in_q), ws_addend, ACC_WIDTH, SATURATE, ws_ovf);
    os_sum    = os_sum_l[ACC_WIDTH-1:0];
    ws_sum    = ws_sum_l[ACC_WIDTH-1:0];
    os_next   = p_vld ? os_sum : (p_clr ? '0 : acc_q);
    ws_vld    = p_vld & psum_vld_in_q;
    unused_hi = ^{os_sum_l[63:ACC_WIDTH], ws_sum_l[63:ACC_WIDTH]};
  end

  // Stage 2: accumulate/drain in OS, stream the partial sum in WS, flush on a mode edge.
  always_comb begin
    acc_d      = acc_q;
    psum_d     = psum_q;
    psum_vld_d = 1'b0;
    sat_d      = sat_q;
    if (mode_chg) begin
      acc_d = '0;
    end else if (mode == MODE_OS) begin
      acc_d = os_next;
      // A beat that overflows while being cleared or unloaded still reports its overflow.
      sat_d = ((p_clr | acc_load) ? 1'b0 : sat_q) | (p_vld & os_ovf);
      if (acc_load) begin
        psum_d     = os_next;
        psum_vld_d = 1'b1;
        acc_d      = '0;
      end else if (acc_shift) begin
        psum_d     = psum_in;
        psum_vld_d = psum_vld_in;
      end
    end else begin
      psum_d     = ws_sum;
      psum_vld_d = ws_vld;
      sat_d      = sat_q | (ws_vld & ws_ovf);
    end
  end

  // Stage-2 state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
      sat_q      <= sat_d;
    end
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign a_vld_out    = a_vld_q;
  assign b_vld_out    = b_vld_q;
  assign clr_out      = clr_q;
  assign psum_out     = psum_q;
  assign psum_vld_out = psum_vld_q;
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - scoreboard bench for systolic_pe in three width/saturation configurations
module tb_systolic_pe;
  import systolic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mode, a_vld_in, clr_in, b_vld_in, w_load, acc_load, acc_shift, psum_vld_in;
  logic [7:0]  a_in, b_in;
  logic [31:0] psum_in32;
  logic [15:0] psum_in16;
  assign psum_in16 = psum_in32[15:0];

  logic [7:0]  a_out [3];
  logic [7:0]  b_out [3];
  logic        a_vld_out [3];
  logic        b_vld_out [3];
  logic        clr_out [3];
  logic        psum_vld_out [3];
  logic        sat_flag [3];
  logic [31:0] psum_out0;
  logic [15:0] psum_out1, psum_out2;

  systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SATURATE(1'b1)) u_pe0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .a_in(a_in), .a_vld_in(a_vld_in), .clr_in(clr_in),
    .b_in(b_in), .b_vld_in(b_vld_in), .w_load(w_load), .acc_load(acc_load), .acc_shift(acc_shift),
    .psum_in(psum_in32), .psum_vld_in(psum_vld_in), .a_out(a_out[0]), .b_out(b_out[0]),
    .a_vld_out(a_vld_out[0]), .b_vld_out(b_vld_out[0]), .clr_out(clr_out[0]),
    .psum_out(psum_out0), .psum_vld_out(psum_vld_out[0]), .sat_flag(sat_flag[0]));

  systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b1)) u_pe1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .a_in(a_in), .a_vld_in(a_vld_in), .clr_in(clr_in),
    .b_in(b_in), .b_vld_in(b_vld_in), .w_load(w_load), .acc_load(acc_load), .acc_shift(acc_shift),
    .psum_in(psum_in16), .psum_vld_in(psum_vld_in), .a_out(a_out[1]), .b_out(b_out[1]),
    .a_vld_out(a_vld_out[1]), .b_vld_out(b_vld_out[1]), .clr_out(clr_out[1]),
    .psum_out(psum_out1), .psum_vld_out(psum_vld_out[1]), .sat_flag(sat_flag[1]));

  systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b0)) u_pe2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .a_in(a_in), .a_vld_in(a_vld_in), .clr_in(clr_in),
    .b_in(b_in), .b_vld_in(b_vld_in), .w_load(w_load), .acc_load(acc_load), .acc_shift(acc_shift),
    .psum_in(psum_in16), .psum_vld_in(psum_vld_in), .a_out(a_out[2]), .b_out(b_out[2]),
    .a_vld_out(a_vld_out[2]), .b_vld_out(b_vld_out[2]), .clr_out(clr_out[2]),
    .psum_out(psum_out2), .psum_vld_out(psum_vld_out[2]), .sat_flag(sat_flag[2]));

  int     total = 0;
  int     bad = 0;
  longint q0[$];
  longint q1[$];
  longint q2[$];
  longint m_acc [3];
  longint m_w;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v, input int w);
    if (w == 16) return longint'($signed(v[15:0]));
    return longint'($signed(v));
  endfunction

  // Reference arithmetic: exact integer sum, then clamp or fold back into the configured range.
  function automatic longint ref_add(input longint a, input longint b, input int k);
    longint s, span, hi, lo;
    int     w;
    w    = (k == 0) ? 32 : 16;
    span = longint'(1) << w;
    hi   = span / 2 - 1;
    lo   = -(span / 2);
    s    = a + b;
    if (s > hi) s = (k != 2) ? hi : s - span;
    else if (s < lo) s = (k != 2) ? lo : s + span;
    return s;
  endfunction

  task automatic push(input int k, input longint v);
    if (k == 0) q0.push_back(v);
    else if (k == 1) q1.push_back(v);
    else q2.push_back(v);
  endtask

  task automatic sb_pop(input int k, input longint act);
    int     n;
    longint e;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      total++;
      bad++;
      $display("FAIL sb%0d_unexpected_psum actual=%0d required=no_output", k, act);
    end else begin
      if (k == 0) e = q0.pop_front();
      else if (k == 1) e = q1.pop_front();
      else e = q2.pop_front();
      check($sformatf("sb%0d_psum_out", k), act, e);
    end
  endtask

  // Model: a beat stream per configuration. An unload returns everything issued in earlier cycles.
  task automatic model_cycle();
    longint a, b, pin;
    a = longint'($signed(a_in));
    b = longint'($signed(b_in));
    for (int k = 0; k < 3; k++) begin
      pin = (k == 0) ? sx(psum_in32, 32) : sx(psum_in32, 16);
      if (mode == MODE_OS) begin
        if (acc_load) begin
          push(k, m_acc[k]);
          m_acc[k] = 0;
        end else if (acc_shift && psum_vld_in) begin
          push(k, pin);
        end
        if (clr_in) m_acc[k] = 0;
        if (a_vld_in && b_vld_in) m_acc[k] = ref_add(m_acc[k], a * b, k);
      end else if (a_vld_in && psum_vld_in) begin
        push(k, ref_add(pin, a * m_w, k));
      end
    end
    if (w_load && b_vld_in) m_w = b;
  endtask

  logic [7:0] pa, pb;
  logic       pav, pbv, pclr, prev_ok;
  initial prev_ok = 1'b0;

  always @(posedge clk) begin
    pa      <= a_in;
    pb      <= b_in;
    pav     <= a_vld_in;
    pbv     <= b_vld_in;
    pclr    <= clr_in;
    prev_ok <= rst_n;
  end

  // Monitor: pops the scoreboards whenever a PE presents a valid psum, and checks forwarding.
  always @(negedge clk) begin
    if (rst_n) begin
      if (psum_vld_out[0]) sb_pop(0, sx(psum_out0, 32));
      if (psum_vld_out[1]) sb_pop(1, sx({16'h0, psum_out1}, 16));
      if (psum_vld_out[2]) sb_pop(2, sx({16'h0, psum_out2}, 16));
      if (prev_ok)
        check("forward", longint'({a_out[0], b_out[0], a_vld_out[0], b_vld_out[0], clr_out[0]}),
              longint'({pa, pb, pav, pbv, pclr}));
    end
  end

  task automatic idle_inputs();
    a_vld_in = 1'b0; clr_in = 1'b0; b_vld_in = 1'b0; w_load = 1'b0;
    acc_load = 1'b0; acc_shift = 1'b0; psum_vld_in = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom); psum_in32 = $urandom;
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin idle_inputs(); tick(); end
  endtask

  task automatic beat(input int a, input int b, input logic clr);
    idle_inputs();
    a_in = 8'(a); b_in = 8'(b); a_vld_in = 1'b1; b_vld_in = 1'b1; clr_in = clr;
    tick();
  endtask

  task automatic ws_beat(input int a, input int p, input logic pv);
    idle_inputs();
    a_in = 8'(a); a_vld_in = 1'b1; psum_in32 = 32'(p); psum_vld_in = pv;
    tick();
  endtask

  task automatic load();
    idle_inputs(); acc_load = 1'b1; tick();
  endtask

  task automatic set_mode(input logic m);
    idle(3);
    mode = m;
    for (int k = 0; k < 3; k++) m_acc[k] = 0;
    idle(3);
  endtask

  task automatic rand_cycle();
    a_in = 8'($urandom); b_in = 8'($urandom); psum_in32 = $urandom;
    a_vld_in = ($urandom_range(0, 99) < 70); b_vld_in = ($urandom_range(0, 99) < 80);
    clr_in = ($urandom_range(0, 99) < 10); acc_load = ($urandom_range(0, 99) < 10);
    acc_shift = ($urandom_range(0, 99) < 15); psum_vld_in = ($urandom_range(0, 99) < 50);
    w_load = ($urandom_range(0, 99) < 15);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; mode = MODE_OS; m_w = 0;
    for (int k = 0; k < 3; k++) m_acc[k] = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", longint'({psum_out0, a_out[0], b_out[0], a_vld_out[0], b_vld_out[0],
          clr_out[0], psum_vld_out[0], sat_flag[0]}), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // OS basic
    beat(3, 4, 1'b1); beat(-5, 6, 1'b0); beat(7, -2, 1'b0); load();
    check("os_basic_psum", sx(psum_out0, 32), -32);
    check("os_basic_vld", longint'(psum_vld_out[0]), 1);
    check("os_basic_sat", longint'(sat_flag[0]), 0);
    idle(1);
    check("os_basic_single_pulse", longint'(psum_vld_out[0]), 0);

    // bubbles with garbage data, then a fresh clear beat
    beat(10, 10, 1'b1);
    repeat (3) begin idle_inputs(); b_vld_in = 1'($urandom); tick(); end
    beat(1, 1, 1'b0);
    repeat (2) begin idle_inputs(); b_vld_in = 1'($urandom); tick(); end
    beat(2, 2, 1'b1); load();
    check("clr_restart_psum", sx(psum_out0, 32), 4);

    // saturation vs wrap
    repeat (3) beat(127, 127, 1'b0);
    idle(1);
    check("sat_flag_acc32", longint'(sat_flag[0]), 0);
    check("sat_flag_sat16", longint'(sat_flag[1]), 1);
    check("sat_flag_wrap16", longint'(sat_flag[2]), 1);
    load();
    check("sat_psum_acc32", sx(psum_out0, 32), 48387);
    check("sat_psum_sat16", sx({16'h0, psum_out1}, 16), 32767);
    check("sat_psum_wrap16", sx({16'h0, psum_out2}, 16), -17149);
    idle(1);
    check("sat_cleared_by_load", longint'({sat_flag[0], sat_flag[1], sat_flag[2]}), 0);

    // drain chain priority
    beat(5, 5, 1'b0);
    idle_inputs(); acc_load = 1'b1; acc_shift = 1'b1; psum_in32 = 999; psum_vld_in = 1'b1; tick();
    check("load_beats_shift", sx(psum_out0, 32), 25);
    idle_inputs(); acc_shift = 1'b1; psum_in32 = 32'(-7777); psum_vld_in = 1'b1; tick();
    check("shift_psum", sx(psum_out0, 32), -7777);
    check("shift_vld", longint'(psum_vld_out[0]), 1);

    // randomized OS traffic
    repeat (400) rand_cycle();
    idle(3);

    // asynchronous reset in the middle of accumulation
    repeat (3) beat(127, 127, 1'b0);
    repeat (5) beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b0);
    a_vld_in = 1'b1; b_vld_in = 1'b1; a_in = 8'h55; b_in = 8'h33; clr_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("async_reset_pe%0d", k), longint'({a_out[k], b_out[k], a_vld_out[k], b_vld_out[k],
            clr_out[k], psum_vld_out[k], sat_flag[k]}), 0);
    check("async_reset_psum", longint'({psum_out0, psum_out1, psum_out2}), 0);
    for (int k = 0; k < 3; k++) m_acc[k] = 0;
    m_w = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    beat(6, 7, 1'b0); load();
    check("post_reset_fresh", sx(psum_out0, 32), 42);

    // WS chain
    set_mode(MODE_WS);
    ws_beat(9, 55, 1'b1); idle(1);
    check("ws_weight_reset", sx(psum_out0, 32), 55);
    idle_inputs(); w_load = 1'b1; b_vld_in = 1'b1; b_in = 8'(-3); tick();
    ws_beat(5, 100, 1'b1); idle(1);
    check("ws_chain_psum", sx(psum_out0, 32), 85);
    check("ws_chain_vld", longint'(psum_vld_out[0]), 1);
    ws_beat(5, 100, 1'b0); idle(1);
    check("ws_psum_vld_gate", longint'(psum_vld_out[0]), 0);
    repeat (300) rand_cycle();
    idle(3);

    // mode toggling clears acc but keeps the weight
    idle_inputs(); w_load = 1'b1; b_vld_in = 1'b1; b_in = 8'd7; tick();
    set_mode(MODE_OS);
    beat(3, 3, 1'b1); beat(3, 3, 1'b0);
    set_mode(MODE_WS);
    ws_beat(4, 10, 1'b1); idle(1);
    check("ws_weight_retained", sx(psum_out0, 32), 38);
    set_mode(MODE_OS);
    load();
    check("mode_clears_acc", sx(psum_out0, 32), 0);
    check("mode_clears_acc_vld", longint'(psum_vld_out[0]), 1);

    idle(4);
    check("sb_drained", longint'(q0.size() + q1.size() + q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
